uart_rx_data_sampler: RTL and testbench

//   Front end of the UART receiver. Contains the per-bit edge counter, the per-frame bit counter
//   and a 3-sample majority-vote data sampler for the oversampled RX_IN line.

---
 rtl/uart_rx_pkg.sv | 44 ++++
 rtl/uart_rx_edge_bit_counter.sv | 46 ++++
 rtl/uart_rx_data_sampler.sv | 83 ++++++++
 tb/tb_uart_rx_data_sampler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants, bit-slot classification and the majority vote
// used by the UART receive front end.
package uart_rx_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int EDGE_CNT_W = 5;
  localparam int BIT_CNT_W  = 4;

  localparam logic [BIT_CNT_W-1:0] START_IDX = '0;
  localparam logic [BIT_CNT_W-1:0] PAR_IDX   = BIT_CNT_W'(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    BIT_START,
    BIT_DATA,
    BIT_PARITY,
    BIT_STOP
  } bit_kind_e;

  // Index of the final bit of a frame; the parity slot shifts the stop bit out by one.
  function automatic logic [BIT_CNT_W-1:0] stop_idx(input logic par_en,
                                                    input int   data_width = DATA_WIDTH);
    return par_en ? BIT_CNT_W'(data_width + 2) : BIT_CNT_W'(data_width + 1);
  endfunction

  function automatic bit_kind_e bit_kind(input logic [BIT_CNT_W-1:0] idx,
                                         input logic                 par_en,
                                         input int                   data_width = DATA_WIDTH);
    bit_kind_e kind;
    if (idx == START_IDX)
      kind = BIT_START;
    else if (int'(idx) <= data_width)
      kind = BIT_DATA;
    else if (par_en && (int'(idx) == data_width + 1))
      kind = BIT_PARITY;
    else
      kind = BIT_STOP;
    return kind;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and per-frame bit counter; frame_done marks the
// final edge of the final bit so consecutive frames need no counter clear.
module uart_rx_edge_bit_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  cnt_en,
  output logic [PRESCALE_W-2:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  frame_done
);

  import uart_rx_pkg::*;

  logic [PRESCALE_W-1:0] edge_ext;
  logic [PRESCALE_W-1:0] last_edge;
  logic [3:0]            last_bit;
  logic                  wrap;

  // Greater-or-equal keeps the counter bounded if prescale shrinks mid-bit.
  assign edge_ext   = PRESCALE_W'(edge_cnt);
  assign last_edge  = prescale - PRESCALE_W'(1);
  assign last_bit   = stop_idx(par_en, DATA_WIDTH);
  assign wrap       = cnt_en && (edge_ext >= last_edge);
  assign frame_done = wrap && (bit_cnt == last_bit);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= (bit_cnt == last_bit) ? 4'd0 : bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART receive front end: counters plus a three-sample majority vote taken
// around the middle of each bit, with a start-bit glitch flag for the FSM.
module uart_rx_data_sampler #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  cnt_en,
  input  logic                  dat_samp_en,
  output logic [PRESCALE_W-2:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  sampled_bit,
  output logic                  samp_vld,
  output logic                  strt_glitch,
  output logic                  frame_done
);

  import uart_rx_pkg::*;

  logic                  s0;
  logic                  s1;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] edge_ext;
  logic                  samp_en;
  logic                  at_s0;
  logic                  at_s1;
  logic                  at_vote;
  logic                  vote;
  logic                  in_start;

  uart_rx_edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_counter (
    .CLK        (CLK),
    .RST        (RST),
    .prescale   (Prescale),
    .par_en     (PAR_EN),
    .cnt_en     (cnt_en),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done)
  );

  // Samples straddle the bit centre: one before, at, and one after it.
  assign mid      = Prescale >> 1;
  assign edge_ext = PRESCALE_W'(edge_cnt);
  assign samp_en  = dat_samp_en && cnt_en;
  assign at_s0    = edge_ext == (mid - PRESCALE_W'(1));
  assign at_s1    = edge_ext == mid;
  assign at_vote  = edge_ext == (mid + PRESCALE_W'(1));
  assign vote     = maj3(s0, s1, RX_IN);
  assign in_start = bit_kind(bit_cnt, PAR_EN, DATA_WIDTH) == BIT_START;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0          <= 1'b1;
      s1          <= 1'b1;
      sampled_bit <= 1'b1;
      samp_vld    <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      samp_vld    <= 1'b0;
      strt_glitch <= 1'b0;
      if (samp_en) begin
        if (at_s0)
          s0 <= RX_IN;
        if (at_s1)
          s1 <= RX_IN;
        if (at_vote) begin
          sampled_bit <= vote;
          samp_vld    <= 1'b1;
          strt_glitch <= vote && in_start;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Self-checking bench for uart_rx_data_sampler: scoreboarded voted bits,
// counter sequencing, glitch rejection, false start and counter clear.
module tb_uart_rx_data_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       cnt_en;
  logic       dat_samp_en;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       samp_vld;
  logic       strt_glitch;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic value;
    logic glitch;
  } exp_t;

  exp_t exp_q[$];

  uart_rx_data_sampler dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .PAR_EN      (PAR_EN),
    .cnt_en      (cnt_en),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sampled_bit (sampled_bit),
    .samp_vld    (samp_vld),
    .strt_glitch (strt_glitch),
    .frame_done  (frame_done)
  );

  always #5 CLK = ~CLK;

  // Leaves the counters cleared and running from edge 0, bit 0, at a falling edge.
  task automatic start_counting(input int p, input logic par);
    @(negedge CLK);
    Prescale    = 6'(p);
    PAR_EN      = par;
    cnt_en      = 1'b0;
    dat_samp_en = 1'b0;
    RX_IN       = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    cnt_en      = 1'b1;
    dat_samp_en = 1'b1;
  endtask

  task automatic stop_counting();
    cnt_en      = 1'b0;
    dat_samp_en = 1'b0;
    RX_IN       = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    checks++;
    if (edge_cnt !== 5'd0) begin errors++; $display("[TB] FAIL reset edge_cnt: got %0d want 0", edge_cnt); end
    checks++;
    if (bit_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset bit_cnt: got %0d want 0", bit_cnt); end
    checks++;
    if (sampled_bit !== 1'b1) begin errors++; $display("[TB] FAIL reset sampled_bit: got %b want 1", sampled_bit); end
    checks++;
    if ({samp_vld, strt_glitch, frame_done} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset strobes: got %b want 000", {samp_vld, strt_glitch, frame_done});
    end

    start_counting(8, 1'b1);
    RX_IN = 1'b0;
    repeat (29) @(negedge CLK);
    checks++;
    if (edge_cnt !== 5'd5 || bit_cnt !== 4'd3) begin
      errors++; $display("[TB] FAIL pre-reset position: got edge %0d bit %0d want edge 5 bit 3", edge_cnt, bit_cnt);
    end
    checks++;
    if (sampled_bit !== 1'b0) begin errors++; $display("[TB] FAIL pre-reset sampled_bit: got %b want 0", sampled_bit); end

    #2 RST = 1'b0;
    #1;
    checks++;
    if (edge_cnt !== 5'd0 || bit_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL async reset counters: got edge %0d bit %0d want 0 0", edge_cnt, bit_cnt);
    end
    checks++;
    if (sampled_bit !== 1'b1) begin errors++; $display("[TB] FAIL async reset sampled_bit: got %b want 1", sampled_bit); end
    checks++;
    if ({samp_vld, strt_glitch, frame_done} !== 3'b000) begin
      errors++; $display("[TB] FAIL async reset strobes: got %b want 000", {samp_vld, strt_glitch, frame_done});
    end
    @(negedge CLK);
    RST = 1'b1;
    stop_counting();
  endtask

  // Prescale 8 with parity: frame 0x55, even parity 0, stop 1.
  task automatic test_parity_frame();
    logic [10:0] bits;
    exp_t        item;
    int          b;
    int          e;
    int          ne;
    bits       = '0;
    bits[8:1]  = 8'h55;
    bits[9]    = 1'b0;
    bits[10]   = 1'b1;
    start_counting(8, 1'b1);
    for (int t = 0; t < 88; t++) begin
      b = t / 8;
      e = t % 8;
      RX_IN = bits[b];
      if (e == 0) exp_q.push_back('{value: bits[b], glitch: (b == 0) && bits[b]});
      checks++;
      if (frame_done !== ((e == 7) && (b == 10))) begin
        errors++; $display("[TB] FAIL par frame_done t=%0d: got %b want %b", t, frame_done, (e == 7) && (b == 10));
      end
      @(negedge CLK);
      ne = (t + 1) % 8;
      checks++;
      if (edge_cnt !== 5'(ne) || bit_cnt !== 4'(((t + 1) / 8) % 11)) begin
        errors++; $display("[TB] FAIL par counters t=%0d: got edge %0d bit %0d want edge %0d bit %0d",
                           t, edge_cnt, bit_cnt, ne, ((t + 1) / 8) % 11);
      end
      checks++;
      if (samp_vld !== (ne == 6)) begin errors++; $display("[TB] FAIL par samp_vld t=%0d: got %b want %b", t, samp_vld, ne == 6); end
      if (samp_vld === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL par scoreboard t=%0d: samp_vld with no expected bit", t);
        end else begin
          item = exp_q.pop_front();
          checks++;
          if (sampled_bit !== item.value) begin errors++; $display("[TB] FAIL par sampled_bit t=%0d: got %b want %b", t, sampled_bit, item.value); end
          checks++;
          if (strt_glitch !== item.glitch) begin errors++; $display("[TB] FAIL par strt_glitch t=%0d: got %b want %b", t, strt_glitch, item.glitch); end
        end
      end else begin
        checks++;
        if (strt_glitch !== 1'b0) begin errors++; $display("[TB] FAIL par strt_glitch idle t=%0d: got %b want 0", t, strt_glitch); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL par leftover bits: got %0d want 0", exp_q.size()); end
    stop_counting();
  endtask

  // Prescale 16 without parity, sampling disabled: pure counter sequencing.
  task automatic test_counters();
    int fd_count;
    int b;
    int e;
    fd_count = 0;
    start_counting(16, 1'b0);
    dat_samp_en = 1'b0;
    for (int t = 0; t < 320; t++) begin
      b = (t / 16) % 10;
      e = t % 16;
      checks++;
      if (frame_done !== ((e == 15) && (b == 9))) begin
        errors++; $display("[TB] FAIL cnt frame_done t=%0d: got %b want %b", t, frame_done, (e == 15) && (b == 9));
      end
      if (frame_done === 1'b1) fd_count++;
      @(negedge CLK);
      checks++;
      if (edge_cnt !== 5'((t + 1) % 16) || bit_cnt !== 4'(((t + 1) / 16) % 10)) begin
        errors++; $display("[TB] FAIL cnt counters t=%0d: got edge %0d bit %0d want edge %0d bit %0d",
                           t, edge_cnt, bit_cnt, (t + 1) % 16, ((t + 1) / 16) % 10);
      end
      checks++;
      if (samp_vld !== 1'b0) begin errors++; $display("[TB] FAIL cnt samp_vld disabled t=%0d: got %b want 0", t, samp_vld); end
    end
    checks++;
    if (fd_count != 2) begin errors++; $display("[TB] FAIL cnt frame_done count: got %0d want 2", fd_count); end
    stop_counting();
  endtask

  // Single-sample disturbances around the centre must not change the vote.
  task automatic test_glitch_reject();
    logic [6:0] bits;
    int         flip_edge[7];
    exp_t       item;
    int         b;
    int         e;
    int         ne;
    bits      = 7'b0101100;
    flip_edge = '{99, 99, 99, 4, 4, 5, 3};
    start_counting(8, 1'b1);
    for (int t = 0; t < 56; t++) begin
      b = t / 8;
      e = t % 8;
      RX_IN = (e == flip_edge[b]) ? ~bits[b] : bits[b];
      if (e == 0) exp_q.push_back('{value: bits[b], glitch: (b == 0) && bits[b]});
      @(negedge CLK);
      ne = (t + 1) % 8;
      checks++;
      if (samp_vld !== (ne == 6)) begin errors++; $display("[TB] FAIL glitch samp_vld t=%0d: got %b want %b", t, samp_vld, ne == 6); end
      if (samp_vld === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL glitch scoreboard t=%0d: samp_vld with no expected bit", t);
        end else begin
          item = exp_q.pop_front();
          checks++;
          if (sampled_bit !== item.value) begin
            errors++; $display("[TB] FAIL glitch sampled_bit bit=%0d: got %b want %b", b, sampled_bit, item.value);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL glitch leftover bits: got %0d want 0", exp_q.size()); end
    stop_counting();
  endtask

  // Prescale 32: line dips briefly then returns high before the centre samples.
  task automatic test_false_start();
    exp_t item;
    int   ne;
    start_counting(32, 1'b0);
    for (int t = 0; t < 32; t++) begin
      RX_IN = (t < 4) ? 1'b0 : 1'b1;
      if (t == 0) exp_q.push_back('{value: 1'b1, glitch: 1'b1});
      @(negedge CLK);
      ne = (t + 1) % 32;
      checks++;
      if (samp_vld !== (ne == 18)) begin errors++; $display("[TB] FAIL fstart samp_vld t=%0d: got %b want %b", t, samp_vld, ne == 18); end
      if (samp_vld === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL fstart scoreboard t=%0d: samp_vld with no expected bit", t);
        end else begin
          item = exp_q.pop_front();
          checks++;
          if (sampled_bit !== item.value) begin errors++; $display("[TB] FAIL fstart sampled_bit: got %b want %b", sampled_bit, item.value); end
          checks++;
          if (strt_glitch !== item.glitch) begin errors++; $display("[TB] FAIL fstart strt_glitch: got %b want %b", strt_glitch, item.glitch); end
        end
      end else begin
        checks++;
        if (strt_glitch !== 1'b0) begin errors++; $display("[TB] FAIL fstart strt_glitch idle t=%0d: got %b want 0", t, strt_glitch); end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL fstart leftover bits: got %0d want 0", exp_q.size()); end
    stop_counting();
  endtask

  // Dropping cnt_en mid-frame clears both counters on the next edge.
  task automatic test_cnt_disable();
    start_counting(8, 1'b1);
    repeat (35) @(negedge CLK);
    checks++;
    if (edge_cnt !== 5'd3 || bit_cnt !== 4'd4) begin
      errors++; $display("[TB] FAIL disable position: got edge %0d bit %0d want edge 3 bit 4", edge_cnt, bit_cnt);
    end
    cnt_en = 1'b0;
    for (int t = 0; t < 8; t++) begin
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL disable frame_done t=%0d: got %b want 0", t, frame_done); end
      @(negedge CLK);
      checks++;
      if (edge_cnt !== 5'd0 || bit_cnt !== 4'd0) begin
        errors++; $display("[TB] FAIL disable counters t=%0d: got edge %0d bit %0d want 0 0", t, edge_cnt, bit_cnt);
      end
      checks++;
      if (samp_vld !== 1'b0) begin errors++; $display("[TB] FAIL disable samp_vld t=%0d: got %b want 0", t, samp_vld); end
    end
    stop_counting();
  endtask

  // Two frames with cnt_en held high throughout: no clear between them.
  task automatic test_back_to_back();
    logic [19:0] bits;
    exp_t        item;
    int          b;
    int          e;
    int          ne;
    int          fd_count;
    bits        = '0;
    bits[8:1]   = 8'hA3;
    bits[9]     = 1'b1;
    bits[18:11] = 8'h3C;
    bits[19]    = 1'b1;
    fd_count    = 0;
    start_counting(8, 1'b0);
    for (int t = 0; t < 160; t++) begin
      b = t / 8;
      e = t % 8;
      RX_IN = bits[b];
      if (e == 0) exp_q.push_back('{value: bits[b], glitch: ((b % 10) == 0) && bits[b]});
      checks++;
      if (frame_done !== ((e == 7) && ((b % 10) == 9))) begin
        errors++; $display("[TB] FAIL b2b frame_done t=%0d: got %b want %b", t, frame_done, (e == 7) && ((b % 10) == 9));
      end
      if (frame_done === 1'b1) fd_count++;
      @(negedge CLK);
      ne = (t + 1) % 8;
      checks++;
      if (bit_cnt !== 4'(((t + 1) / 8) % 10)) begin
        errors++; $display("[TB] FAIL b2b bit_cnt t=%0d: got %0d want %0d", t, bit_cnt, ((t + 1) / 8) % 10);
      end
      checks++;
      if (samp_vld !== (ne == 6)) begin errors++; $display("[TB] FAIL b2b samp_vld t=%0d: got %b want %b", t, samp_vld, ne == 6); end
      if (samp_vld === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL b2b scoreboard t=%0d: samp_vld with no expected bit", t);
        end else begin
          item = exp_q.pop_front();
          checks++;
          if (sampled_bit !== item.value) begin errors++; $display("[TB] FAIL b2b sampled_bit t=%0d: got %b want %b", t, sampled_bit, item.value); end
          checks++;
          if (strt_glitch !== item.glitch) begin errors++; $display("[TB] FAIL b2b strt_glitch t=%0d: got %b want %b", t, strt_glitch, item.glitch); end
        end
      end
    end
    checks++;
    if (fd_count != 2) begin errors++; $display("[TB] FAIL b2b frame_done count: got %0d want 2", fd_count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b leftover bits: got %0d want 0", exp_q.size()); end
    stop_counting();
  endtask

  initial begin
    RST         = 1'b0;
    RX_IN       = 1'b1;
    Prescale    = 6'd8;
    PAR_EN      = 1'b0;
    cnt_en      = 1'b0;
    dat_samp_en = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    test_reset();
    test_parity_frame();
    test_counters();
    test_glitch_reject();
    test_false_start();
    test_cnt_disable();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
